noc_rr_arbiter: RTL and testbench

Round-robin, packet-locking arbiter that sits directly upstream of the NoC output-port mux and drives its `sel` input. It takes `num_inputs` valid/ready flit streams and grants one requester at a time. The grant is held until that requester's tail flit is transferred. Each input's flit data is concatenated onto the mux `in_bus`, and the mux output is qualified by this block's `out_valid`.

---
 rtl/noc_rr_arbiter_pkg.sv | 24 ++
 rtl/noc_rr_arbiter_if.sv | 30 +++
 rtl/noc_rr_arbiter_rr_pick.sv | 40 ++++
 rtl/noc_rr_arbiter.sv | 89 ++++++++
 tb/tb_noc_rr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_rr_arbiter_pkg.sv
// Shared constants and helpers for the NoC round-robin arbiter.
// Latency: none (types, FSM encodings and a constant function only).
// Backpressure: not applicable.
package noc_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Bits needed to index 'value' entries; never less than one bit.
    function automatic int clogb2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// Request/grant bundle between flit sources, the arbiter and the output mux.
// Latency: none (wires only).
// Backpressure: req_ready/out_ready carry the valid-ready handshake.
interface noc_rr_arbiter_if
    import noc_rr_arbiter_pkg::*;
#(
    parameter int num_inputs = 4
);
    localparam int sel_w = clogb2(num_inputs);

    logic [num_inputs-1:0] req_valid;
    logic [num_inputs-1:0] req_tail;
    logic [num_inputs-1:0] req_ready;
    logic [num_inputs-1:0] grant;
    logic [sel_w-1:0]      sel;
    logic                  out_valid;
    logic                  out_ready;

    // Sources and the downstream sink drive the master side.
    modport master (
        output req_valid, req_tail, out_ready,
        input  req_ready, grant, sel, out_valid
    );

    modport slave (
        input  req_valid, req_tail, out_ready,
        output req_ready, grant, sel, out_valid
    );

endinterface

// File: rtl/noc_rr_arbiter_rr_pick.sv
// Round-robin winner selection: first valid request above 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is registered.
module noc_rr_arbiter_rr_pick
    import noc_rr_arbiter_pkg::*;
#(
    parameter  int num_inputs = 4,
    localparam int sel_w      = clogb2(num_inputs)
) (
    input  logic [num_inputs-1:0] req_valid,
    input  logic [sel_w-1:0]      last,
    output logic                  any,
    output logic [num_inputs-1:0] win_onehot,
    output logic [sel_w-1:0]      win_idx
);
    localparam int dbl_w = clogb2(2 * num_inputs);

    logic [2*num_inputs-1:0] dbl;
    logic [dbl_w-1:0]        pos;

    // Doubling the vector turns the wrap-around scan into a straight upward scan.
    assign dbl = {req_valid, req_valid};

    always_comb begin
        any     = 1'b0;
        win_idx = '0;
        pos     = '0;
        for (int i = 1; i <= num_inputs; i++) begin
            pos = dbl_w'(last) + dbl_w'(i);
            if (!any && dbl[pos]) begin
                any     = 1'b1;
                win_idx = (pos >= dbl_w'(num_inputs)) ? sel_w'(pos - dbl_w'(num_inputs))
                                                       : sel_w'(pos);
            end
        end
    end

    assign win_onehot = any ? (num_inputs'(1) << win_idx) : '0;

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter driving the NoC output mux select; NOC_ARB_LOCK_EN holds grant until tail.
// Latency: grant/sel registered the cycle after a request is seen in IDLE; one bubble between grants.
// Backpressure: granted input's req_ready follows out_ready; every other req_ready stays low.
module noc_rr_arbiter
    import noc_rr_arbiter_pkg::*;
#(
    parameter int num_inputs = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_rr_arbiter_if.slave      bus
);
    localparam int sel_w = clogb2(num_inputs);

    arb_state_t            state;
    logic [num_inputs-1:0] grant_q;
    logic [sel_w-1:0]      sel_q;
    logic [sel_w-1:0]      last_q;

    logic                  pick_any;
    logic [num_inputs-1:0] pick_onehot;
    logic [sel_w-1:0]      pick_idx;

    logic                  out_vld;
    logic                  xfer;
    logic                  pkt_end;

    noc_rr_arbiter_rr_pick #(
        .num_inputs (num_inputs)
    ) u_pick (
        .req_valid  (bus.req_valid),
        .last       (last_q),
        .any        (pick_any),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx)
    );

`ifdef NOC_ARB_LOCK_EN
    assign pkt_end = bus.req_tail[sel_q];
`else
    // Per-flit arbitration: every accepted flit releases the grant.
    assign pkt_end = 1'b1;
    logic unused_tail;
    assign unused_tail = ^bus.req_tail;
`endif

    assign out_vld = (state == BUSY) && bus.req_valid[sel_q];
    assign xfer    = out_vld && bus.out_ready;

    always_comb begin
        bus.out_valid = out_vld;
        bus.req_ready = '0;
        if (state == BUSY && bus.out_ready) begin
            bus.req_ready[sel_q] = 1'b1;
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;

    // sel keeps its value through IDLE; only grant is cleared when a packet ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= sel_w'(num_inputs - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state   <= BUSY;
                        grant_q <= pick_onehot;
                        sel_q   <= pick_idx;
                        last_q  <= pick_idx;
                    end
                end
                BUSY: begin
                    if (xfer && pkt_end) begin
                        state   <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Self-checking bench for noc_rr_arbiter: vector table plus scoreboarded packet sequences.
module tb_noc_rr_arbiter;
    import noc_rr_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int SW = clogb2(N);
`ifdef NOC_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [SW-1:0] sel;
        logic          out_valid;
        logic [N-1:0]  req_ready;
    } exp_t;

    typedef struct packed {
        logic [N-1:0] rv;
        logic [N-1:0] tail;
        logic         ordy;
        exp_t         e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_rr_arbiter_if #(.num_inputs(N)) bus ();
    noc_rr_arbiter #(.num_inputs(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t sb_q[$];
    int   xfer_log[$];
    int   first3_cyc;
    int   first_g0_cyc;
    logic [N-1:0] first_grant;

    // Reference model state
    logic          m_busy;
    logic [N-1:0]  m_grant;
    logic [SW-1:0] m_sel;
    logic [SW-1:0] m_last;

    // Packet sources
    int flits_left [N];
    int pkts_left  [N];
    int len        [N];
    int drop       [N];
    int start_dly  [N];

    vec_t tab [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cycle=%0d: got %0h, expected %0h", name, cyc, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] rv, input logic [N-1:0] tl, input logic ordy,
                                input logic [N-1:0] g, input int s, input logic ov,
                                input logic [N-1:0] rr);
        vec_t v;
        v.rv          = rv;
        v.tail        = tl;
        v.ordy        = ordy;
        v.e.grant     = g;
        v.e.sel       = SW'(s);
        v.e.out_valid = ov;
        v.e.req_ready = rr;
        return v;
    endfunction

    function automatic exp_t model_out(input logic [N-1:0] rv, input logic ordy);
        exp_t e;
        e.grant     = m_grant;
        e.sel       = m_sel;
        e.out_valid = m_busy && rv[m_sel];
        e.req_ready = '0;
        if (m_busy && ordy) e.req_ready[m_sel] = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_grant = '0;
        m_sel   = '0;
        m_last  = SW'(N - 1);
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] rv, input logic [N-1:0] tl,
                              input logic ordy);
        int idx;
        if (r) begin
            model_reset();
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                idx = (int'(m_last) + k) % N;
                if (rv[idx]) begin
                    m_busy  = 1'b1;
                    m_grant = N'(1) << idx;
                    m_sel   = SW'(idx);
                    m_last  = SW'(idx);
                    break;
                end
            end
        end else if (rv[m_sel] && ordy && (!LOCK || tl[m_sel])) begin
            m_busy  = 1'b0;
            m_grant = '0;
        end
    endtask

    task automatic drive_cycle(input logic r, input logic [N-1:0] rv, input logic [N-1:0] tl,
                               input logic ordy, input logic use_tab, input exp_t tab_e);
        exp_t e;
        rst           = r;
        bus.req_valid = rv;
        bus.req_tail  = tl;
        bus.out_ready = ordy;
        if (use_tab) sb_q.push_back(tab_e);
        else         sb_q.push_back(model_out(rv, ordy));
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("grant",     32'(bus.grant),     32'(e.grant));
            check("sel",       32'(bus.sel),       32'(e.sel));
            check("out_valid", 32'(bus.out_valid), 32'(e.out_valid));
            check("req_ready", 32'(bus.req_ready), 32'(e.req_ready));
        end
        if (bus.out_valid && bus.out_ready) begin
            xfer_log.push_back(int'(bus.sel));
            if (bus.sel == SW'(3) && first3_cyc < 0) first3_cyc = cyc;
        end
        if (bus.grant[0] && first_g0_cyc < 0) first_g0_cyc = cyc;
        if (bus.grant != '0 && first_grant == '0) first_grant = bus.grant;
        model_step(r, rv, tl, ordy);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input int i, input int plen, input int npkts, input int dly);
        flits_left[i] = plen;
        len[i]        = plen;
        pkts_left[i]  = npkts - 1;
        start_dly[i]  = dly;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            flits_left[i] = 0;
            pkts_left[i]  = 0;
            len[i]        = 0;
            drop[i]       = 0;
            start_dly[i]  = 0;
        end
    endtask

    function automatic bit sources_busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < N; i++) if (flits_left[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic gen_cycle(input logic ordy, input logic r);
        logic [N-1:0] rv;
        logic [N-1:0] tl;
        logic         mx;
        int           ms;
        for (int i = 0; i < N; i++) begin
            rv[i] = (flits_left[i] > 0) && (drop[i] == 0) && (start_dly[i] == 0);
            tl[i] = (flits_left[i] == 1);
        end
        mx = !r && m_busy && rv[m_sel] && ordy;
        ms = int'(m_sel);
        drive_cycle(r, rv, tl, ordy, 1'b0, '0);
        if (mx) begin
            flits_left[ms]--;
            if (flits_left[ms] == 0 && pkts_left[ms] > 0) begin
                pkts_left[ms]--;
                flits_left[ms] = len[ms];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (drop[i] > 0)      drop[i]--;
            if (start_dly[i] > 0) start_dly[i]--;
        end
    endtask

    task automatic run_until_idle(input logic ordy, input int max_cyc);
        int n;
        n = 0;
        while (sources_busy() && n < max_cyc) begin
            gen_cycle(ordy, 1'b0);
            n++;
        end
        check("drain_timeout", 32'(sources_busy()), 32'd0);
        gen_cycle(ordy, 1'b0);
    endtask

    task automatic check_log(input string name, input int exp_q[$]);
        check({name, "_count"}, 32'(xfer_log.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            check(name, (k < xfer_log.size()) ? 32'(xfer_log[k]) : 32'hffff_ffff, 32'(exp_q[k]));
        end
    endtask

    initial begin
        int exp_q[$];

        tab[0]  = mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 0, 1'b0, 4'b0000);
        tab[1]  = mk(4'b0110, 4'b1111, 1'b1, 4'b0000, 0, 1'b0, 4'b0000);
        tab[2]  = mk(4'b0110, 4'b1111, 1'b1, 4'b0010, 1, 1'b1, 4'b0010);
        tab[3]  = mk(4'b0110, 4'b1111, 1'b1, 4'b0000, 1, 1'b0, 4'b0000);
        tab[4]  = mk(4'b0110, 4'b1111, 1'b1, 4'b0100, 2, 1'b1, 4'b0100);
        tab[5]  = mk(4'b0110, 4'b1111, 1'b1, 4'b0000, 2, 1'b0, 4'b0000);
        tab[6]  = mk(4'b0110, 4'b1111, 1'b1, 4'b0010, 1, 1'b1, 4'b0010);
        tab[7]  = mk(4'b0110, 4'b1111, 1'b1, 4'b0000, 1, 1'b0, 4'b0000);
        tab[8]  = mk(4'b0110, 4'b1111, 1'b1, 4'b0100, 2, 1'b1, 4'b0100);
        tab[9]  = mk(4'b1000, 4'b1111, 1'b0, 4'b0000, 2, 1'b0, 4'b0000);
        tab[10] = mk(4'b1000, 4'b1111, 1'b0, 4'b1000, 3, 1'b1, 4'b0000);
        tab[11] = mk(4'b1000, 4'b1111, 1'b1, 4'b1000, 3, 1'b1, 4'b1000);
        tab[12] = mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 3, 1'b0, 4'b0000);

        clear_sources();
        model_reset();
        first3_cyc    = -1;
        first_g0_cyc  = -1;
        first_grant   = '0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_tail  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, then single-flit round robin between inputs 1 and 2, then a stall.
        for (int i = 0; i < 13; i++) begin
            drive_cycle(1'b0, tab[i].rv, tab[i].tail, tab[i].ordy, 1'b1, tab[i].e);
        end

        // Input 3 four-flit packet, input 0 requesting from the next cycle.
        xfer_log.delete();
        first3_cyc   = -1;
        first_g0_cyc = -1;
        load(3, 4, 1, 0);
        load(0, 1, 3, 1);
        run_until_idle(1'b1, 60);
        if (LOCK) exp_q = '{3, 3, 3, 3, 0, 0, 0};
        else      exp_q = '{3, 0, 3, 0, 3, 0, 3};
        check_log("pkt_lock_order", exp_q);
        check("grant0_delay", 32'(first_g0_cyc - first3_cyc), LOCK ? 32'd5 : 32'd2);

        // Downstream stall of five cycles mid-packet.
        xfer_log.delete();
        load(1, 4, 1, 0);
        gen_cycle(1'b1, 1'b0);
        gen_cycle(1'b1, 1'b0);
        repeat (5) gen_cycle(1'b0, 1'b0);
        run_until_idle(1'b1, 40);
        exp_q = '{1, 1, 1, 1};
        check_log("stall_xfers", exp_q);

        // Granted input drops valid for three cycles while inputs 0 and 3 request.
        xfer_log.delete();
        load(2, 4, 1, 0);
        gen_cycle(1'b1, 1'b0);
        gen_cycle(1'b1, 1'b0);
        drop[2] = 3;
        load(0, 1, 1, 0);
        load(3, 1, 1, 0);
        run_until_idle(1'b1, 40);
        if (LOCK) exp_q = '{2, 2, 2, 2, 3, 0};
        else      exp_q = '{2, 3, 0, 2, 2, 2};
        check_log("drop_valid_order", exp_q);

        // Reset during the second flit, then all four inputs request.
        load(1, 4, 1, 0);
        gen_cycle(1'b1, 1'b0);
        gen_cycle(1'b1, 1'b0);
        gen_cycle(1'b1, 1'b1);
        clear_sources();
        first_grant = '0;
        xfer_log.delete();
        for (int i = 0; i < N; i++) load(i, 1, 1, 0);
        run_until_idle(1'b1, 40);
        check("first_grant_after_rst", 32'(first_grant), 32'h1);
        exp_q = '{0, 1, 2, 3};
        check_log("post_rst_order", exp_q);

        // Inputs 0 and 1 each send a three-flit packet.
        gen_cycle(1'b1, 1'b1);
        xfer_log.delete();
        load(0, 3, 1, 0);
        load(1, 3, 1, 0);
        run_until_idle(1'b1, 60);
        if (LOCK) exp_q = '{0, 0, 0, 1, 1, 1};
        else      exp_q = '{0, 1, 0, 1, 0, 1};
        check_log("two_src_order", exp_q);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
